// File: rtl/arb_2ph_sync_if.sv
// Bundle of the arbiter's two-phase handshake signals: the N requester
// channels, the shared consumer channel and the status outputs.
interface arb_2ph_sync_if #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
);
    logic [N-1:0]  r_in;
    logic [N-1:0]  a_in;
    logic          r;
    logic          a;
    logic [IW-1:0] gnt_id;
    logic          busy;
    logic          err;

    // master is the arbiter itself; slave is the surrounding environment
    modport master (
        input  r_in, a,
        output a_in, r, gnt_id, busy, err
    );

    modport slave (
        output r_in, a,
        input  a_in, r, gnt_id, busy, err
    );
endinterface

// File: rtl/arb_2ph_sync.sv
// Clocked round-robin arbiter that multiplexes N two-phase requester channels
// onto one two-phase output channel, with synchronized inputs and error flag.
module arb_2ph_sync #(
    parameter int N           = 2,
    parameter int SYNC_STAGES = 2,
    parameter int IW          = $clog2(N)
) (
    input  logic             clk,
    input  logic             rstn,
    arb_2ph_sync_if.master   bus
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0][N-1:0] r_sync_q, r_sync_d;
    logic [SYNC_STAGES-1:0]        a_sync_q, a_sync_d;

    logic [N-1:0]  rs, rs_next, pending;
    logic          as, as_next;
    logic [N-1:0]  a_in_q, a_in_d;
    logic          r_q, r_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] winner;
    logic          found;
    logic          acked;
    logic          violation;

    assign r_sync_d = {r_sync_q[SYNC_STAGES-2:0], bus.r_in};
    assign a_sync_d = {a_sync_q[SYNC_STAGES-2:0], bus.a};
    assign rs       = r_sync_q[SYNC_STAGES-1];
    assign rs_next  = r_sync_q[SYNC_STAGES-2];
    assign as       = a_sync_q[SYNC_STAGES-1];
    assign as_next  = a_sync_q[SYNC_STAGES-2];

    assign pending   = rs ^ a_in_q;
    assign found     = |pending;
    assign acked     = (state_q == WAIT) && (as == r_q);
    assign violation = (|((rs_next ^ rs) & pending))
                     || ((state_q == IDLE) && (as_next != as));

    // Second scan overrides the first, so indices above last outrank the wrap-around ones
    always_comb begin
        winner = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i] && (i <= int'(last_q))) winner = IW'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(last_q))) winner = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = WAIT;
            WAIT:    if (acked) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        r_d    = r_q;
        a_in_d = a_in_q;
        gnt_d  = gnt_q;
        busy_d = busy_q;
        last_d = last_q;
        err_d  = err_q | violation;
        if ((state_q == IDLE) && found) begin
            gnt_d  = winner;
            r_d    = ~r_q;
            busy_d = 1'b1;
        end
        if (acked) begin
            a_in_d[gnt_q] = ~a_in_q[gnt_q];
            last_d        = gnt_q;
            busy_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync_q <= '0;
            a_sync_q <= '0;
            a_in_q   <= '0;
            r_q      <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            gnt_q    <= '0;
            last_q   <= IW'(N - 1);
        end else begin
            r_sync_q <= r_sync_d;
            a_sync_q <= a_sync_d;
            a_in_q   <= a_in_d;
            r_q      <= r_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
        end
    end

    assign bus.a_in   = a_in_q;
    assign bus.r      = r_q;
    assign bus.gnt_id = gnt_q;
    assign bus.busy   = busy_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_arb_2ph_sync.sv
// Scoreboard bench for arb_2ph_sync: stimulus pushes expected grants and
// acknowledge vectors, a negedge monitor pops and compares on every event.
module tb_arb_2ph_sync;

    localparam int N         = 4;
    localparam int S         = 2;
    localparam int IW        = $clog2(N);
    localparam int ACK_DELAY = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    arb_2ph_sync_if #(.N(N)) bus ();

    arb_2ph_sync #(.N(N), .SYNC_STAGES(S)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [IW-1:0] gnt_q_exp[$];
    logic [N-1:0]  ack_q_exp[$];
    bit            sb_enable = 1'b1;

    int r_toggles  = 0;
    int ack_events = 0;
    int multi_ack  = 0;
    int ain_toggles[N];

    logic         prev_r = 1'b0;
    logic [N-1:0] prev_a = '0;

    int ack_wait  = 0;
    int rand_left = 0;
    int re_req[N];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s", name);
    endtask

    // Monitor: every r toggle is a grant, every a_in change is a completed transaction
    initial begin
        for (int i = 0; i < N; i++) ain_toggles[i] = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_r = 1'b0;
                prev_a = '0;
            end else begin
                if (bus.r !== prev_r) begin
                    r_toggles++;
                    prev_r = bus.r;
                    if (sb_enable) begin
                        if (gnt_q_exp.size() == 0) reportFail("unexpected grant");
                        else begin
                            checkOutput("grant gnt_id", 32'(bus.gnt_id), 32'(gnt_q_exp.pop_front()));
                            checkOutput("grant busy", 32'(bus.busy), 32'd1);
                        end
                    end
                end
                if (bus.a_in !== prev_a) begin
                    logic [N-1:0] diff;
                    diff = bus.a_in ^ prev_a;
                    if ($countones(diff) > 1) multi_ack++;
                    for (int i = 0; i < N; i++) if (diff[i]) ain_toggles[i]++;
                    ack_events++;
                    prev_a = bus.a_in;
                    if (sb_enable) begin
                        if (ack_q_exp.size() == 0) reportFail("unexpected ack");
                        else begin
                            checkOutput("ack a_in", 32'(bus.a_in), 32'(ack_q_exp.pop_front()));
                            checkOutput("ack busy", 32'(bus.busy), 32'd0);
                        end
                    end
                end
            end
        end
    end

    task automatic applyReset();
        rstn       = 1'b0;
        bus.r_in   = '0;
        bus.a      = 1'b0;
        ack_wait   = 0;
        rand_left  = 0;
        for (int i = 0; i < N; i++) re_req[i] = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Drives the consumer and the requester agents until target_acks transactions complete
    task automatic applyStimulus(input int target_acks, input int budget, input bit random_mode);
        int           start_acks;
        int           cyc;
        logic [N-1:0] seen_a;
        start_acks = ack_events;
        cyc        = 0;
        seen_a     = bus.a_in;
        while ((ack_events - start_acks < target_acks) && (cyc < budget)) begin
            @(negedge clk);
            cyc++;
            if (bus.r !== bus.a) begin
                if (ack_wait >= ACK_DELAY) begin
                    bus.a    = bus.r;
                    ack_wait = 0;
                end else ack_wait++;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.a_in[i] !== seen_a[i]) begin
                    seen_a[i] = bus.a_in[i];
                    if (re_req[i] > 0) begin
                        bus.r_in[i] = ~bus.r_in[i];
                        re_req[i]--;
                    end
                end else if (random_mode && (rand_left > 0) && (bus.r_in[i] === bus.a_in[i])
                             && ($urandom_range(0, 3) == 0)) begin
                    bus.r_in[i] = ~bus.r_in[i];
                    rand_left--;
                end
            end
        end
        if (ack_events - start_acks < target_acks) reportFail("agent timeout waiting for acks");
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int           r_start;
        int           ain_start[N];
        int           ain_sum;
        int           multi_start;
        logic [N-1:0] exp_a;

        bus.r_in = '0;
        bus.a    = 1'b0;

        $display("[TB] reset values");
        @(negedge clk);
        checkOutput("reset r", 32'(bus.r), 32'd0);
        checkOutput("reset a_in", 32'(bus.a_in), 32'd0);
        checkOutput("reset gnt_id", 32'(bus.gnt_id), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset err", 32'(bus.err), 32'd0);
        applyReset();

        $display("[TB] single requester latency");
        gnt_q_exp.push_back(IW'(0));
        ack_q_exp.push_back(4'b0001);
        bus.r_in[0] = 1'b1;
        repeat (S) @(posedge clk);
        @(negedge clk);
        checkOutput("r not early", 32'(bus.r), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("r after S+1 edges", 32'(bus.r), 32'd1);
        checkOutput("gnt_id single", 32'(bus.gnt_id), 32'd0);
        checkOutput("busy single", 32'(bus.busy), 32'd1);
        bus.a = 1'b1;
        repeat (S) @(posedge clk);
        @(negedge clk);
        checkOutput("a_in not early", 32'(bus.a_in), 32'd0);
        checkOutput("busy held in WAIT", 32'(bus.busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("a_in after S+1 edges", 32'(bus.a_in), 32'h1);
        checkOutput("busy after ack", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("no regrant after ack", 32'(bus.busy), 32'd0);
        checkOutput("gnt_id held in IDLE", 32'(bus.gnt_id), 32'd0);

        $display("[TB] simultaneous requests");
        applyReset();
        gnt_q_exp.push_back(IW'(0));
        ack_q_exp.push_back(4'b0001);
        gnt_q_exp.push_back(IW'(1));
        ack_q_exp.push_back(4'b0011);
        r_start = r_toggles;
        bus.r_in[1:0] = 2'b11;
        applyStimulus(2, 200, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("simultaneous r toggles", 32'(r_toggles - r_start), 32'd2);
        checkOutput("simultaneous a_in", 32'(bus.a_in), 32'h3);

        $display("[TB] round-robin fairness");
        applyReset();
        exp_a = '0;
        for (int k = 0; k < 20; k++) begin
            gnt_q_exp.push_back(IW'(k % N));
            exp_a[k % N] = ~exp_a[k % N];
            ack_q_exp.push_back(exp_a);
        end
        for (int i = 0; i < N; i++) begin
            re_req[i]    = 4;
            ain_start[i] = ain_toggles[i];
        end
        bus.r_in = '1;
        applyStimulus(20, 2000, 1'b0);
        repeat (8) @(negedge clk);
        for (int i = 0; i < N; i++)
            checkOutput($sformatf("a_in[%0d] toggle count", i), 32'(ain_toggles[i] - ain_start[i]), 32'd5);
        checkOutput("fairness final a_in", 32'(bus.a_in), 32'hF);
        checkOutput("fairness busy idle", 32'(bus.busy), 32'd0);
        checkOutput("fairness err", 32'(bus.err), 32'd0);

        $display("[TB] random traffic");
        applyReset();
        sb_enable   = 1'b0;
        r_start     = r_toggles;
        multi_start = multi_ack;
        for (int i = 0; i < N; i++) ain_start[i] = ain_toggles[i];
        rand_left = 1000;
        applyStimulus(1000, 40000, 1'b1);
        repeat (10) @(negedge clk);
        ain_sum = 0;
        for (int i = 0; i < N; i++) ain_sum += ain_toggles[i] - ain_start[i];
        checkOutput("random r toggles vs acks", 32'(r_toggles - r_start), 32'(ain_sum));
        checkOutput("random ack count", 32'(ain_sum), 32'd1000);
        checkOutput("random err", 32'(bus.err), 32'd0);
        checkOutput("random multi ack", 32'(multi_ack - multi_start), 32'd0);
        sb_enable = 1'b1;

        $display("[TB] protocol violation and async reset");
        applyReset();
        gnt_q_exp.push_back(IW'(1));
        bus.r_in[1] = 1'b1;
        repeat (S + 1) @(posedge clk);
        @(negedge clk);
        checkOutput("violation busy", 32'(bus.busy), 32'd1);
        checkOutput("violation err before", 32'(bus.err), 32'd0);
        bus.r_in[1] = 1'b0;
        repeat (S + 1) @(posedge clk);
        @(negedge clk);
        checkOutput("err set", 32'(bus.err), 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("err sticky", 32'(bus.err), 32'd1);
        checkOutput("still in WAIT", 32'(bus.busy), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("async reset r", 32'(bus.r), 32'd0);
        checkOutput("async reset a_in", 32'(bus.a_in), 32'd0);
        checkOutput("async reset busy", 32'(bus.busy), 32'd0);
        checkOutput("async reset err", 32'(bus.err), 32'd0);
        bus.r_in = '0;
        bus.a    = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("scoreboard drained", 32'(gnt_q_exp.size() + ack_q_exp.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
